dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Memory-stage controller between the EX/MEM and MEM/WB pipeline registers.
- Converts the single-cycle MemRead/MemWrite/ALUResult/RS2data request into a req/ack handshake with a variable-latency data memory.
- Holds the pipeline with stall_o until the access completes, then presents load data to MEM/WB.
- Detects misaligned word accesses, enforces a bus timeout, and counts completed accesses.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: data width.
- TIMEOUT, 16: maximum WAIT-state cycles before a bus error. Minimum legal value is 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- addr_i  in  ADDR_W  ALU result, the byte address.
- wdata_i  in  DATA_W  store data (RS2data).
- rdata_o  out  DATA_W  load data to MEM/WB, registered.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- misalign_o  out  1  combinational; access requested with addr_i[1:0]!=0.
- bus_err_o  out  1  high for the DONE cycle of a timed-out access.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = write, 0 = read, registered.
- mem_addr_o  out  ADDR_W  word-aligned address, registered.
- mem_wdata_o  out  DATA_W  write data, registered.
- mem_ack_i  in  1  memory completion, a 1-cycle pulse.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i is high.
- access_cnt_o  out  32  count of completed accesses (ack or timeout).

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - rdata_o=0, bus_err_o=0, access_cnt_o=0, timeout counter=0.
- Reset asserted mid-access: mem_req_o drops immediately (asynchronous) and any pending ack is lost.
- Access defined: acc = (MemRead_i | MemWrite_i) & (addr_i[1:0]==0).
- Misaligned: misalign_o = (MemRead_i | MemWrite_i) & (addr_i[1:0]!=0), in any state.
  - A misaligned access is never issued and never stalls.
  - rdata_o and access_cnt_o are unchanged.
- Read/write priority: MemRead_i and MemWrite_i both high is treated as a write.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - stall_o = acc, combinational, same cycle.
  - If acc: next state WAIT; register mem_req_o=1, mem_we_o=MemWrite_i, mem_addr_o={addr_i[ADDR_W-1:2],2'b00}, mem_wdata_o=wdata_i; clear timeout counter.
- WAIT:
  - stall_o=1 and mem_req_o held at 1.
  - Address, data and we are stable until the handshake ends.
  - Counter increments each WAIT cycle without ack.
  - If mem_ack_i: next state DONE, mem_req_o<=0, access_cnt_o increments (wraps at 2^32). If not a write, rdata_o<=mem_rdata_i.
  - Else if counter==TIMEOUT-1: next state DONE, mem_req_o<=0, bus_err_o<=1, rdata_o<=0 for reads, access_cnt_o increments.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - stall_o=0, so the pipeline advances this cycle and MEM/WB captures rdata_o.
  - Next state IDLE unconditionally; bus_err_o<=0.
  - DONE ignores inputs so the instruction still on the EX/MEM outputs is not reissued.
- mem_ack_i outside WAIT: ignored.
- Latency: access completing k cycles after request gives stall_o high for k+1 cycles.
  - Minimum total is 3 cycles per access: IDLE, WAIT, DONE.
- Back-to-back accesses: a new acc is accepted in the IDLE cycle following DONE. No bubble beyond DONE.
- Stores: rdata_o is unchanged on a store.

Test Plan:
- Read, ack after 3 WAIT cycles: MemRead_i=1, addr_i=0x100, mem_rdata_i=0xDEADBEEF. Expect mem_addr_o=0x100, mem_we_o=0; stall_o high for 4 cycles then low 1 cycle; rdata_o=0xDEADBEEF; access_cnt_o=1.
- Write, ack in first WAIT cycle: MemWrite_i=1, addr_i=0x204, wdata_i=0x12345678. Expect mem_we_o=1, mem_wdata_o=0x12345678; stall 2 cycles; rdata_o unchanged.
- Misaligned: MemRead_i=1, addr_i=0x102. Expect misalign_o=1, stall_o=0, mem_req_o stays 0, access_cnt_o unchanged.
- Timeout with TIMEOUT=4 and no ack: expect mem_req_o high for 4 cycles then 0, bus_err_o=1 for exactly 1 cycle, rdata_o=0. Repeat with ack on the 4th WAIT cycle: expect bus_err_o=0 and rdata_o = ack data.
- Reset mid-WAIT: assert rst_i=0 asynchronously between clock edges. Expect mem_req_o=0 and stall_o=0 immediately. After release, ack pulses are ignored and the next access starts cleanly from IDLE.
- Back-to-back read then write with immediate acks: two completions in 6 cycles, access_cnt_o=2, and no duplicate request from the DONE cycle.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage FSM turning one-cycle load/store requests into a req/ack
// memory handshake, with pipeline stall, misalignment detection, bus timeout and access count.
module dmem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       access_cnt_o
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [CW-1:0]     tmo_q, tmo_d;
    logic              any_req, acc;

    assign any_req    = MemRead_i | MemWrite_i;
    assign acc        = any_req & (addr_i[1:0] == 2'b00);
    assign misalign_o = any_req & (addr_i[1:0] != 2'b00);
    assign stall_o    = (state_q == IDLE) ? acc : (state_q == WAIT);

    assign rdata_o      = rdata_q;
    assign bus_err_o    = err_q;
    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign access_cnt_o = cnt_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: if (acc) begin
                state_d = WAIT;
                req_d   = 1'b1;
                we_d    = MemWrite_i;
                addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                wdata_d = wdata_i;
                tmo_d   = '0;
            end
            // ack takes priority over a timeout landing on the same cycle
            WAIT: if (mem_ack_i) begin
                state_d = DONE;
                req_d   = 1'b0;
                cnt_d   = cnt_q + 32'd1;
                rdata_d = we_q ? rdata_q : mem_rdata_i;
            end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                state_d = DONE;
                req_d   = 1'b0;
                err_d   = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                rdata_d = we_q ? rdata_q : '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule
